// File: rtl/fir_pkg.sv
// Shared widths, sample/result types and saturation-limit helper for the fir_17 datapath.
package fir_pkg;

  localparam int FIR_DATA_W = 8;
  localparam int FIR_ACC_W  = 24;

  typedef logic signed [FIR_DATA_W-1:0] fir_sample_t;
  typedef logic signed [FIR_ACC_W-1:0]  fir_result_t;

  typedef struct packed {
    logic signed [31:0] hi;
    logic signed [31:0] lo;
  } sat_lim_t;

  // Largest and smallest two's-complement values representable in out_w bits.
  function automatic sat_lim_t sat_limits(input int out_w);
    sat_lim_t lim;
    lim.hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lim.lo = -(32'sd1 <<< (out_w - 1));
    return lim;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy counter; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module fir_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is left unreset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (rst && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/fir_out_quant.sv
// fir_17 output quantizer: round-half-up, arithmetic shift, saturate to OUT_W, buffer in a FIFO.
// Define FIR_OUT_QUANT_STATS_EN to add saturating sat_cnt_o / drop_cnt_o event counters.
module fir_out_quant
  import fir_pkg::*;
#(
  parameter int IN_W  = FIR_ACC_W,
  parameter int OUT_W = FIR_DATA_W,
  parameter int SHIFT = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [IN_W-1:0]     data_i,
  input  logic                       valid_i,
  output logic signed [OUT_W-1:0]    data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       sat_o,
`ifdef FIR_OUT_QUANT_STATS_EN
  output logic [15:0]                sat_cnt_o,
  output logic [15:0]                drop_cnt_o,
`endif
  output logic                       ovf_o
);

  localparam int SW = IN_W + 1;
  localparam sat_lim_t LIM = sat_limits(OUT_W);
  localparam logic signed [SW-1:0] Q_MAX = SW'(LIM.hi);
  localparam logic signed [SW-1:0] Q_MIN = SW'(LIM.lo);
  localparam logic signed [SW-1:0] RND   = SW'(1) <<< (SHIFT - 1);

  logic signed [SW-1:0]  sum, q;
  logic [OUT_W-1:0]      word_d, word_q;
  logic                  s1_valid_q;
  logic                  sat_evt, sat_q, sat_d;
  logic                  ovf_q, ovf_d;
  logic                  pop, push, drop, fifo_full, fifo_empty;
  logic [OUT_W-1:0]      fifo_rdata;

  // One extra bit of headroom so adding the rounding constant cannot wrap.
  assign sum = SW'(data_i) + RND;
  assign q   = sum >>> SHIFT;

  always_comb begin
    word_d  = q[OUT_W-1:0];
    sat_evt = 1'b0;
    if (q > Q_MAX) begin
      word_d  = Q_MAX[OUT_W-1:0];
      sat_evt = valid_i;
    end else if (q < Q_MIN) begin
      word_d  = Q_MIN[OUT_W-1:0];
      sat_evt = valid_i;
    end
  end

  assign pop   = valid_o && ready_i;
  assign push  = s1_valid_q && (!fifo_full || pop);
  assign drop  = s1_valid_q && fifo_full && !pop;
  assign sat_d = sat_q | sat_evt;
  assign ovf_d = ovf_q | drop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      word_q     <= '0;
      s1_valid_q <= 1'b0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (valid_i) word_q <= word_d;
      s1_valid_q <= valid_i;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
    end
  end

  fir_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (word_q),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign data_o  = fifo_rdata;
  assign valid_o = !fifo_empty;
  assign sat_o   = sat_q;
  assign ovf_o   = ovf_q;

`ifdef FIR_OUT_QUANT_STATS_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    sat_cnt_d  = sat_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (sat_evt && sat_cnt_q != 16'hFFFF) sat_cnt_d  = sat_cnt_q + 16'd1;
    if (drop && drop_cnt_q != 16'hFFFF)   drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sat_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      sat_cnt_q  <= sat_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign sat_cnt_o  = sat_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule
